// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: default geometry, the hardwired
// zero address and the address-validity rule used by both write and read paths.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_DEPTH     = 32;
  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned REG_ZERO_ADDR = 0;

  // An address selects real storage when it is inside the array and is not the
  // hardwired zero word.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input int unsigned depth,
                                   input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == REG_ZERO_ADDR));
  endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word of the register file: a WIDTH-bit register with a load
// enable and a synchronous active-low clear.
module reg_word #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;

  // Clear on reset (reset beats enable), otherwise load when enabled.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: every word is a discrete flop with a clear, so zeroing the whole file on reset is legitimate here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if (ena) begin
      data_q <= data_in;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/reg_file_np.sv
// Multi-port register file: one synchronous write port, two combinational
// read ports, optional hardwired zero word and optional write-to-read bypass.
module reg_file_np
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);

  logic             waddr_ok;
  logic             raddr1_ok;
  logic             raddr2_ok;
  logic             fwd1;
  logic             fwd2;
  logic [WIDTH-1:0] word_q [DEPTH];

  assign waddr_ok  = addr_ok(32'(waddr),  DEPTH, ZERO_REG);
  assign raddr1_ok = addr_ok(32'(raddr1), DEPTH, ZERO_REG);
  assign raddr2_ok = addr_ok(32'(raddr2), DEPTH, ZERO_REG);

  // Forwarding only when the write will actually land; reset suppresses it.
  assign fwd1 = BYPASS && rst && we && waddr_ok && (waddr == raddr1);
  assign fwd2 = BYPASS && rst && we && waddr_ok && (waddr == raddr2);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG && (i == REG_ZERO_ADDR)) begin : g_zero
      assign word_q[i] = '0;
    end else begin : g_store
      logic ena;
      assign ena = we && waddr_ok && (waddr == ADDR_W'(i));
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .data_in  (wdata),
        .data_out (word_q[i])
      );
    end
  end

  // Read port 1: forwarded write data, stored word, or zero for invalid addresses.
  // NOTE: the zero default first keeps the output assigned on every path, so no latch is inferred.
  always_comb begin
    rdata1 = '0;
    if (raddr1_ok) begin
      rdata1 = word_q[raddr1];
    end
    if (fwd1) begin
      rdata1 = wdata;
    end
  end

  // Read port 2: same selection as port 1, independent address.
  always_comb begin
    rdata2 = '0;
    if (raddr2_ok) begin
      rdata2 = word_q[raddr2];
    end
    if (fwd2) begin
      rdata2 = wdata;
    end
  end

endmodule
